// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue feeding the fetch/decode pipeline
// register. Issues sequential instruction-memory requests, buffers up to DEPTH
// returned {pc, instruction} entries and presents the head entry to decode
// with a valid/ack handshake. A branch redirect flushes the queue and refetches.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   imem_req/addr      fetch request and address (held while imem_wait)
//   imem_wait/rdata    memory stall and returned instruction
//   ins_out/pc_out     head-entry instruction and PC
//   ins_valid/ins_ack  head-entry handshake with decode
//   redirect/_pc       flush and restart fetching at redirect_pc
//   count              occupied entries
module ifetch_queue #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(32'h0040_0000)
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    imem_req,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic                    imem_wait,
  input  logic [WIDTH-1:0]        imem_rdata,
  output logic [WIDTH-1:0]        ins_out,
  output logic [ADDR_WIDTH-1:0]   pc_out,
  output logic                    ins_valid,
  input  logic                    ins_ack,
  input  logic                    redirect,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [WIDTH-1:0]      ins;
  } entry_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  req_d;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count_inc;
  logic [CNT_W-1:0]      count_d;
  logic                  push;
  logic                  pop;
  entry_t                mem_q [DEPTH];

  // Head-entry presentation; a redirect masks the stale head immediately.
  assign ins_valid = (count != '0) & ~redirect;
  assign pop       = ins_ack & ins_valid;
  assign ins_out   = mem_q[rd_ptr].ins;
  assign pc_out    = mem_q[rd_ptr].pc;

  // Occupancy after a completing push in FETCH (pop may coincide).
  assign count_inc = count + CNT_W'(1) - CNT_W'(pop);

  // Next-state, next fetch PC and next request address.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = imem_addr;
    push       = 1'b0;
    req_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = S_FETCH;
        end else if (count < CNT_W'(DEPTH)) begin
          state_d = S_FETCH;
        end
        addr_d = fetch_pc_d;
      end
      S_FETCH: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          // An in-flight request must finish at its old address before retargeting.
          if (imem_wait) state_d = S_DRAIN;
          else           addr_d  = redirect_pc;
        end else if (!imem_wait) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
          addr_d     = fetch_pc_d;
          if (count_inc == CNT_W'(DEPTH)) state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (!imem_wait) begin
          state_d = S_FETCH;
          addr_d  = fetch_pc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d != S_IDLE);
  end

  // Occupancy update; redirect empties the queue.
  always_comb begin
    count_d = count;
    if (redirect) count_d = '0;
    else          count_d = count + CNT_W'(push) - CNT_W'(pop);
  end

  // State, request outputs and queue storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      imem_addr  <= RESET_PC;
      imem_req   <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      imem_addr  <= addr_d;
      imem_req   <= req_d;
      count      <= count_d;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr] <= {imem_addr, imem_rdata};
          wr_ptr        <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule
